// File: rtl/reset_sequencer.sv
// reset_sequencer: multi-source reset controller that filters the requests, stretches the reset,
// and releases the outputs in ascending order STAGE_GAP cycles apart.
module reset_sequencer #(
   parameter int NUM_SRC     = 2,
   parameter int NUM_OUT     = 3,
   parameter int FILT_CYCLES = 3,
   parameter int STRETCH_W   = 4,
   parameter int MIN_STRETCH = 5,
   parameter int STAGE_GAP   = 5
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic [NUM_SRC-1:0]   i_rst_src,
   input  logic [NUM_SRC-1:0]   i_src_mask,
   input  logic [STRETCH_W-1:0] i_stretch,
   input  logic                 i_cause_clr,
   output logic [NUM_OUT-1:0]   o_rst_sync,
   output logic [NUM_SRC-1:0]   o_rst_cause,
   output logic                 o_por_flag,
   output logic                 o_busy,
   output logic                 o_seq_done
);
   localparam int FW = $clog2(FILT_CYCLES + 1);
   localparam int GW = $clog2(STAGE_GAP + 1);
   localparam int CW = (STRETCH_W > GW) ? STRETCH_W : GW;

   typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, IDLE} state_t;

   state_t               state, state_n;
   logic [NUM_SRC-1:0]   s1, s2, filt, cause, cause_n;
   logic [NUM_OUT-1:0]   sync, sync_n, shifted;
   logic [CW-1:0]        cnt, cnt_n;
   logic [STRETCH_W-1:0] s_val;
   logic                 trig, done, done_n, por, por_n;

   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= i_rst_src;
         s2 <= s1;
      end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_filt
      logic [FW-1:0] fcnt;
      logic          f;
      always_ff @(posedge clk or negedge i_rst_n)
         if (!i_rst_n) begin
            fcnt <= '0;
            f    <= 1'b0;
         end else if (!s2[g]) begin
            fcnt <= '0;
            f    <= 1'b0;
         end else if (fcnt == FW'(FILT_CYCLES - 1))
            f <= 1'b1;
         else
            fcnt <= fcnt + FW'(1);
      assign filt[g] = f;
   end

   assign trig    = |(filt & i_src_mask);
   assign s_val   = (i_stretch < STRETCH_W'(MIN_STRETCH)) ? STRETCH_W'(MIN_STRETCH) : i_stretch;
   assign shifted = sync << 1;

   // Releasing a stage shifts a zero in from the bottom, so bit 0 always falls first.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sync_n  = sync;
      done_n  = 1'b0;
      cause_n = i_cause_clr ? '0 : cause;
      por_n   = por & ~i_cause_clr;
      if (state != HOLD && trig) begin
         state_n = HOLD;
         cnt_n   = '0;
         sync_n  = '1;
         cause_n = cause_n | (filt & i_src_mask);
      end else begin
         case (state)
            HOLD: if (!trig) begin
               state_n = STRETCH;
               cnt_n   = CW'(s_val);
            end
            STRETCH, RELEASE: if (cnt == CW'(1)) begin
               sync_n  = shifted;
               cnt_n   = CW'(STAGE_GAP);
               state_n = (shifted == '0) ? IDLE : RELEASE;
               done_n  = shifted == '0;
            end else
               cnt_n = cnt - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state <= HOLD;
         cnt   <= '0;
         sync  <= '1;
         done  <= 1'b0;
         cause <= '0;
         por   <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sync  <= sync_n;
         done  <= done_n;
         cause <= cause_n;
         por   <= por_n;
      end

   assign o_rst_sync  = sync;
   assign o_rst_cause = cause;
   assign o_por_flag  = por;
   assign o_busy      = state != IDLE;
   assign o_seq_done  = done;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus random traffic against a timing-rule reference model.
module tb_reset_sequencer;
   localparam int NS = 2, NO = 3, FILT = 3, SW = 4, MINS = 5, GAP = 5;
   localparam int VW = NO + NS + 3;

   logic          clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
   logic [NS-1:0] src = '0, mask = '1;
   logic [SW-1:0] stretch = SW'(8);
   logic [NO-1:0] sync;
   logic [NS-1:0] cause;
   logic          por, busy, done;
   logic [VW-1:0] obs;
   int            vecs = 0, errs = 0;

   reset_sequencer #(.NUM_SRC(NS), .NUM_OUT(NO), .FILT_CYCLES(FILT), .STRETCH_W(SW),
                     .MIN_STRETCH(MINS), .STAGE_GAP(GAP)) dut (
      .clk(clk), .i_rst_n(rst_n), .i_rst_src(src), .i_src_mask(mask), .i_stretch(stretch),
      .i_cause_clr(clr), .o_rst_sync(sync), .o_rst_cause(cause), .o_por_flag(por),
      .o_busy(busy), .o_seq_done(done));

   always #5 clk = ~clk;
   assign obs = {sync, busy, done, cause, por};

   // Reference model: timer t counts edges since the stretch load; stage i is released once t >= S + i*GAP.
   logic          m_hold, m_por;
   int            m_t, m_s;
   int            m_run [NS];
   logic [NS-1:0] m_filt, m_h0, m_h1, m_cause;

   task automatic model_reset();
      m_hold = 1'b1; m_t = 0; m_s = 0; m_por = 1'b1;
      m_filt = '0; m_h0 = '0; m_h1 = '0; m_cause = '0;
      for (int i = 0; i < NS; i++) m_run[i] = 0;
   endtask

   task automatic model_edge();
      logic [NS-1:0] set;
      logic entry;
      set   = m_filt & mask;
      entry = 1'b0;
      if (m_hold) begin
         if (set == '0) begin
            m_hold = 1'b0; m_t = 0; m_s = (int'(stretch) < MINS) ? MINS : int'(stretch);
         end
      end else if (set != '0) begin
         m_hold = 1'b1; entry = 1'b1;
      end else
         m_t++;
      m_cause = (clr ? '0 : m_cause) | (entry ? set : '0);
      if (clr) m_por = 1'b0;
      for (int i = 0; i < NS; i++) begin
         m_run[i]  = m_h1[i] ? m_run[i] + 1 : 0;
         m_filt[i] = m_run[i] >= FILT;
      end
      m_h1 = m_h0;
      m_h0 = src;
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [NO-1:0] s;
      int fin;
      fin = m_s + (NO - 1) * GAP;
      for (int i = 0; i < NO; i++) s[i] = m_hold || (m_t < m_s + i * GAP);
      return {s, m_hold || (m_t < fin), !m_hold && (m_t == fin), m_cause, m_por};
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) model_reset();
      else model_edge();

   task automatic test_reset();
      logic [NO-1:0] e;
      #1 rst_n = 1'b0;
      src = '0; stretch = SW'(8);
      repeat (3) begin
         @(negedge clk);
         vecs++;
         if (obs !== {3'b111, 1'b1, 1'b0, 2'b00, 1'b1}) begin
            errs++; $display("FAIL reset_values got=%b exp=%b", obs, {3'b111, 1'b1, 1'b0, 2'b00, 1'b1});
         end
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         e = {k < 19, k < 14, k < 9};
         vecs++;
         if (sync !== e || done !== (k == 19) || por !== 1'b1) begin
            errs++; $display("FAIL power_on edge=%0d sync=%b done=%b por=%b exp sync=%b done=%b por=1", k, sync, done, por, e, k == 19);
         end
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL power_on_model edge=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 12; k++) begin
         src[0] = k < 2;
         @(negedge clk);
         vecs++;
         if (sync !== 3'b000 || busy !== 1'b0 || cause !== 2'b00) begin
            errs++; $display("FAIL glitch k=%0d sync=%b busy=%b cause=%b exp 000/0/00", k, sync, busy, cause);
         end
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL glitch_model k=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
   endtask

   task automatic test_valid();
      logic [NO-1:0] e;
      stretch = SW'(8);
      for (int k = 0; k < 32; k++) begin
         src[0] = k <= 5;
         @(negedge clk);
         e = (k < 5) ? 3'b000 : {k < 27, k < 22, k < 17};
         vecs++;
         if (sync !== e || busy !== (k >= 5 && k < 27) || done !== (k == 27)) begin
            errs++; $display("FAIL valid k=%0d sync=%b busy=%b done=%b exp sync=%b", k, sync, busy, done, e);
         end
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL valid_model k=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
      vecs++;
      if (cause !== 2'b01) begin
         errs++; $display("FAIL valid_cause got=%b exp=01", cause);
      end
   endtask

   task automatic test_clamp_mask();
      logic [NO-1:0] e;
      stretch = SW'(2);
      for (int k = 0; k < 27; k++) begin
         src[0] = k <= 5;
         @(negedge clk);
         e = (k < 5) ? 3'b000 : {k < 24, k < 19, k < 14};
         vecs++;
         if (sync !== e || done !== (k == 24)) begin
            errs++; $display("FAIL clamp k=%0d sync=%b done=%b exp sync=%b", k, sync, done, e);
         end
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL clamp_model k=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
      mask = 2'b01;
      for (int k = 0; k < 15; k++) begin
         src[1] = k <= 5;
         @(negedge clk);
         vecs++;
         if (sync !== 3'b000 || busy !== 1'b0 || cause !== 2'b01) begin
            errs++; $display("FAIL mask k=%0d sync=%b busy=%b cause=%b exp 000/0/01", k, sync, busy, cause);
         end
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL mask_model k=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
      mask = 2'b11;
   endtask

   task automatic test_retrigger();
      logic [NO-1:0] e;
      stretch = SW'(8);
      for (int k = 0; k < 48; k++) begin
         src[0] = k <= 5;
         src[1] = k >= 18 && k <= 23;
         @(negedge clk);
         e = (k < 5) ? 3'b000 : (k < 23) ? {k < 27, k < 22, k < 17} : {k < 45, k < 40, k < 35};
         vecs++;
         if (sync !== e || done !== (k == 45) || busy !== (k >= 5 && k < 45)) begin
            errs++; $display("FAIL retrigger k=%0d sync=%b busy=%b done=%b exp sync=%b", k, sync, busy, done, e);
         end
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL retrigger_model k=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
      vecs++;
      if (cause !== 2'b11) begin
         errs++; $display("FAIL retrigger_cause got=%b exp=11", cause);
      end
   endtask

   task automatic test_cause_clear();
      for (int k = 0; k < 30; k++) begin
         src[0] = k <= 5;
         clr    = k == 5;
         @(negedge clk);
         if (k == 4 || k == 5) begin
            vecs++;
            if (cause !== ((k == 5) ? 2'b01 : 2'b11) || por !== (k == 4)) begin
               errs++; $display("FAIL cause_clear k=%0d cause=%b por=%b exp cause=%b por=%b", k, cause, por, (k == 5) ? 2'b01 : 2'b11, k == 4);
            end
         end
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL cause_clear_model k=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      vecs++;
      if (cause !== 2'b00 || por !== 1'b0) begin
         errs++; $display("FAIL lone_clear cause=%b por=%b exp 00/0", cause, por);
      end
   endtask

   task automatic test_random();
      int left [NS];
      for (int i = 0; i < NS; i++) left[i] = 1;
      for (int k = 0; k < 4000; k++) begin
         for (int i = 0; i < NS; i++) begin
            left[i]--;
            if (left[i] <= 0) begin
               src[i]  = ~src[i];
               left[i] = src[i] ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 60));
            end
         end
         if ($urandom_range(0, 63) == 0) mask = NS'($urandom);
         stretch = SW'($urandom);
         clr     = $urandom_range(0, 49) == 0;
         rst_n   = $urandom_range(0, 999) != 0;
         @(negedge clk);
         vecs++;
         if (obs !== model_vec()) begin
            errs++; $display("FAIL random k=%0d got=%b exp=%b", k, obs, model_vec());
         end
      end
      rst_n = 1'b1; clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_valid();
      test_clamp_mask();
      test_retrigger();
      test_cause_clear();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-source reset controller. It synchronises and glitch-filters NUM_SRC asynchronous active-high reset requests, stretches the combined reset by a run-time-programmable count, and releases NUM_OUT synchronous reset outputs in order, STAGE_GAP cycles apart. It records which source caused each reset. It is the generalised successor of the three-output reset controller and sits at the clock-domain root, driving downstream block resets.

## Interface
- NUM_SRC, 2: number of reset request inputs (1..8).
- NUM_OUT, 3: number of sequenced reset outputs (1..8).
- FILT_CYCLES, 3: consecutive synchronised-high cycles needed to accept a request (≥1).
- STRETCH_W, 4: width of i_stretch.
- MIN_STRETCH, 5: lower clamp on the stretch count (1..2^STRETCH_W-1).
- STAGE_GAP, 5: cycles between successive output releases (≥1).

Ports:
- clk  in  1  single clock for all logic.
- i_rst_n  in  1  asynchronous, active-low power-on reset.
- i_rst_src  in  NUM_SRC  asynchronous active-high reset requests.
- i_src_mask  in  NUM_SRC  1 = source enabled, 0 = ignored; synchronous to clk.
- i_stretch  in  STRETCH_W  stretch count; sampled only when the stretch counter loads.
- i_cause_clr  in  1  one-cycle pulse that clears o_rst_cause and o_por_flag.
- o_rst_sync  out  NUM_OUT  active-high resets; bit 0 is released first.
- o_rst_cause  out  NUM_SRC  sticky record of the sources that triggered a reset.
- o_por_flag  out  1  sticky; set by i_rst_n.
- o_busy  out  1  high in any state other than IDLE.
- o_seq_done  out  1  one-cycle pulse when the last output releases.

## Operation
- Per source: a 2-flop synchroniser feeds a filter counter. The filtered bit sets when the synchroniser output has been high on FILT_CYCLES consecutive edges. It clears on the first edge after the synchroniser output is seen low. The counter restarts on any low sample.
- trig = OR over (filtered & i_src_mask). Masked sources keep filtering but do not contribute.
- S = max(i_stretch, MIN_STRETCH), taken when the stretch counter loads.
- FSM states:
  - HOLD (reset state): all outputs asserted. If trig = 0, load counter = S and go to STRETCH.
  - STRETCH: decrement every edge. On the edge the count would reach 0, deassert o_rst_sync[0], load the gap counter with STAGE_GAP and go to RELEASE (if NUM_OUT = 1, go to IDLE and pulse o_seq_done).
  - RELEASE: on gap expiry, deassert the next output. After the last output deasserts, pulse o_seq_done and go to IDLE.
  - IDLE: all outputs 0, o_busy = 0.
- trig = 1 in STRETCH, RELEASE or IDLE: on the next edge, reassert all outputs, go to HOLD and discard the counters. The full sequence restarts after trig falls.
- Cause: on every entry to HOLD caused by trig, OR the unmasked filtered bits into o_rst_cause.
  - i_cause_clr clears o_rst_cause and o_por_flag.
  - If a set and a clear land on the same edge, the set wins for the bits being set.
- Release order is strictly ascending. A lower-index output is never asserted while a higher-index one is deasserted.

## Timing
- Values while i_rst_n = 0, applied asynchronously:
  - o_rst_sync = all 1, o_busy = 1.
  - o_seq_done = 0, o_rst_cause = 0, o_por_flag = 1.
  - FSM = HOLD; synchronisers, filters and counters = 0.
- Power-on: the counter loads on the first edge after i_rst_n deasserts (edge 1). o_rst_sync[0] falls on edge 1+S. Bit i falls on edge 1+S+i·STAGE_GAP.
- Assertion latency: let edge 0 be the first edge that samples a source high. o_rst_sync goes all-1 on edge FILT_CYCLES+2; for the default, that is edge 5.
- Deassertion: let edge 0 be the first edge that samples all enabled sources low. o_rst_sync[0] falls on edge S+3. Bit i falls on edge S+3+i·STAGE_GAP.
- o_seq_done is registered on the edge the last output falls and is high for exactly one cycle.
- A request shorter than FILT_CYCLES sampled edges never asserts anything.
- All outputs are registered, with no combinational path from inputs.

## Test plan
- Power-on: hold i_rst_n low 3 cycles, i_stretch = 8, sources low.
  - Outputs 3'b111 during reset.
  - Bits 0, 1 and 2 fall on edges 9, 14 and 19 after i_rst_n rises.
  - o_seq_done pulses on edge 19; o_por_flag = 1.
- Glitch rejection: src0 high for 2 sampled edges, from IDLE.
  - o_rst_sync stays 0, o_busy stays 0, o_rst_cause = 0.
- Valid request: src0 high for 6 edges, i_stretch = 8.
  - All outputs assert 5 edges after the first high sample.
  - Release at S+3, +5, +10 edges after the first low sample.
  - o_rst_cause = 2'b01.
- Clamp and mask:
  - i_stretch = 2: stage 0 releases 5+3 edges after the first low sample.
  - Src1 pulse with i_src_mask[1] = 0: no reset and o_rst_cause[1] = 0.
- Retrigger mid-release: src1 request after output 0 has fallen.
  - All outputs reassert 5 edges after the first high sample.
  - The full stretch and release sequence restarts; o_rst_cause = 2'b11.
- Cause clear: i_cause_clr pulsed on the same edge as a new src0 entry to HOLD.
  - o_rst_cause = 2'b01 and o_por_flag = 0.
  - A later lone i_cause_clr gives 2'b00.
